// File: rtl/vga_palette_ctrl_if.sv
// rtl/vga_palette_ctrl_if.sv - button/mode inputs and VGA outputs of the palette controller
interface vga_palette_ctrl_if #(
  parameter int COLOR_W = 4
);
  logic               BTN_NEXT;
  logic               BTN_PREV;
  logic               MODE;
  logic [COLOR_W-1:0] VGA_R;
  logic [COLOR_W-1:0] VGA_G;
  logic [COLOR_W-1:0] VGA_B;
  logic               VGA_HSYNC;
  logic               VGA_VSYNC;

  modport master (
    output BTN_NEXT, BTN_PREV, MODE,
    input  VGA_R, VGA_G, VGA_B, VGA_HSYNC, VGA_VSYNC
  );

  modport slave (
    input  BTN_NEXT, BTN_PREV, MODE,
    output VGA_R, VGA_G, VGA_B, VGA_HSYNC, VGA_VSYNC
  );
endinterface

// File: rtl/vga_palette_ctrl.sv
// rtl/vga_palette_ctrl.sv - VGA timing generator showing a button-selected palette entry
// as a solid field or as rotating vertical bars; selection changes only at frame start.
module vga_palette_ctrl #(
  parameter int COLOR_W      = 4,
  parameter int N_COLORS     = 8,
  parameter int DEBOUNCE_CYC = 500_000,
  parameter int H_VIS        = 640,
  parameter int H_FP         = 16,
  parameter int H_PW         = 96,
  parameter int H_BP         = 48,
  parameter int V_VIS        = 480,
  parameter int V_FP         = 10,
  parameter int V_PW         = 2,
  parameter int V_BP         = 33
) (
  input logic               CLK50MHZ,
  input logic               RST,
  vga_palette_ctrl_if.slave bus
);
  localparam int H_TOT = H_VIS + H_FP + H_PW + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_PW + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);
  localparam int DW    = $clog2(DEBOUNCE_CYC + 1);
  localparam int BAR_W = H_VIS / N_COLORS;
  localparam int BW    = $clog2(BAR_W + 1);

  logic          phase;
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic [2:0]    bar_idx;
  logic [BW-1:0] bar_px;
  logic          h_last;
  logic          v_last;
  logic          frame_start;

  assign h_last      = (h == HW'(H_TOT - 1));
  assign v_last      = (v == VW'(V_TOT - 1));
  assign frame_start = (h == '0) && (v == '0);

  // phase is the pixel enable itself: high every second clock, low right after reset
  always_ff @(posedge CLK50MHZ or negedge RST) begin
    if (!RST) begin
      phase   <= 1'b0;
      h       <= '0;
      v       <= '0;
      bar_idx <= '0;
      bar_px  <= '0;
    end else begin
      phase <= ~phase;
      if (phase) begin
        if (h_last) begin
          h       <= '0;
          bar_idx <= '0;
          bar_px  <= '0;
          v       <= v_last ? '0 : v + 1'b1;
        end else begin
          h <= h + 1'b1;
          if (bar_idx != 3'(N_COLORS - 1)) begin
            if (bar_px == BW'(BAR_W - 1)) begin
              bar_px  <= '0;
              bar_idx <= bar_idx + 1'b1;
            end else begin
              bar_px <= bar_px + 1'b1;
            end
          end
        end
      end
    end
  end

  logic [1:0]    raw;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    accepted;
  logic [1:0]    armed;
  logic [1:0]    pulse;
  logic [1:0]    primed;
  logic [DW-1:0] cnt [2];

  assign raw = {bus.BTN_PREV, bus.BTN_NEXT};

  // A button only arms once it has been seen released after reset, so one held
  // through reset cannot produce a press until it is let go and pressed again.
  always_ff @(posedge CLK50MHZ or negedge RST) begin
    if (!RST) begin
      sync1    <= '0;
      sync2    <= '0;
      accepted <= '0;
      armed    <= '0;
      pulse    <= '0;
      primed   <= '0;
      cnt[0]   <= '0;
      cnt[1]   <= '0;
    end else begin
      primed <= {primed[0], 1'b1};
      sync1  <= raw;
      sync2  <= sync1;
      for (int i = 0; i < 2; i++) begin
        pulse[i] <= 1'b0;
        if (primed[1] && !sync2[i])
          armed[i] <= 1'b1;
        if (sync2[i] != accepted[i]) begin
          if (cnt[i] == DW'(DEBOUNCE_CYC - 1)) begin
            cnt[i]      <= '0;
            accepted[i] <= sync2[i];
            pulse[i]    <= sync2[i] & armed[i];
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  logic [2:0] pend;
  logic [2:0] disp;
  logic       mode_q;

  always_ff @(posedge CLK50MHZ or negedge RST) begin
    if (!RST) begin
      pend   <= '0;
      disp   <= '0;
      mode_q <= 1'b0;
    end else begin
      if (pulse[0] && !pulse[1])
        pend <= (pend == 3'(N_COLORS - 1)) ? 3'd0 : pend + 1'b1;
      else if (pulse[1] && !pulse[0])
        pend <= (pend == 3'd0) ? 3'(N_COLORS - 1) : pend - 1'b1;
      if (phase && frame_start) begin
        disp   <= pend;
        mode_q <= bus.MODE;
      end
    end
  end

  logic [2:0] idx_eff;
  logic       mode_eff;
  logic [3:0] bar_sum;
  logic [3:0] bar_wrap;
  logic [2:0] entry;
  logic       visible;
  logic       hs_low;
  logic       vs_low;

  // Pixel (0,0) already shows the value being loaded, so the whole frame is uniform.
  always_comb begin
    idx_eff  = frame_start ? pend : disp;
    mode_eff = frame_start ? bus.MODE : mode_q;
    bar_sum  = {1'b0, idx_eff} + {1'b0, bar_idx};
    bar_wrap = (bar_sum >= 4'(N_COLORS)) ? bar_sum - 4'(N_COLORS) : bar_sum;
    entry    = mode_eff ? bar_wrap[2:0] : idx_eff;
    visible  = (h < HW'(H_VIS)) && (v < VW'(V_VIS));
    hs_low   = (h >= HW'(H_VIS + H_FP)) && (h <= HW'(H_VIS + H_FP + H_PW - 1));
    vs_low   = (v >= VW'(V_VIS + V_FP)) && (v <= VW'(V_VIS + V_FP + V_PW - 1));
  end

  always_ff @(posedge CLK50MHZ or negedge RST) begin
    if (!RST) begin
      bus.VGA_R     <= '0;
      bus.VGA_G     <= '0;
      bus.VGA_B     <= '0;
      bus.VGA_HSYNC <= 1'b1;
      bus.VGA_VSYNC <= 1'b1;
    end else begin
      bus.VGA_R     <= {COLOR_W{visible & entry[0]}};
      bus.VGA_G     <= {COLOR_W{visible & entry[1]}};
      bus.VGA_B     <= {COLOR_W{visible & entry[2]}};
      bus.VGA_HSYNC <= ~hs_low;
      bus.VGA_VSYNC <= ~vs_low;
    end
  end
endmodule

// File: tb/tb_vga_palette_ctrl.sv
// tb/tb_vga_palette_ctrl.sv - directed bench for vga_palette_ctrl on a shrunken 80x14 raster
module tb_vga_palette_ctrl;
  localparam int H_VIS = 66, H_FP = 4, H_PW = 8, H_BP = 2;
  localparam int V_VIS = 8, V_FP = 2, V_PW = 2, V_BP = 2;
  localparam int H_TOT = H_VIS + H_FP + H_PW + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_PW + V_BP;
  localparam int LIMIT = 3 * 2 * H_TOT * V_TOT;
  localparam int PRESS_CYC = 60;

  logic        clk;
  logic        rst_n;
  logic [11:0] rgb;
  int          check_cnt = 0;
  int          pass_cnt = 0;

  vga_palette_ctrl_if #(.COLOR_W(4)) bus ();

  vga_palette_ctrl #(
    .COLOR_W(4), .N_COLORS(8), .DEBOUNCE_CYC(16),
    .H_VIS(H_VIS), .H_FP(H_FP), .H_PW(H_PW), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_PW(V_PW), .V_BP(V_BP)
  ) dut (
    .CLK50MHZ(clk),
    .RST(rst_n),
    .bus(bus.slave)
  );

  assign rgb = {bus.VGA_R, bus.VGA_G, bus.VGA_B};

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic wait_edge(input bit use_v, input bit level_after, output bit ok, output int n);
    logic prev, cur;
    ok = 1'b0;
    n = 0;
    prev = use_v ? bus.VGA_VSYNC : bus.VGA_HSYNC;
    for (int i = 0; i < LIMIT && !ok; i++) begin
      @(negedge clk);
      n++;
      cur = use_v ? bus.VGA_VSYNC : bus.VGA_HSYNC;
      if (cur != prev && cur == level_after) ok = 1'b1;
      prev = cur;
    end
  endtask

  // Lands on the negedge where the outputs show pixel (hx,vy) of the frame after the next VSYNC fall.
  task automatic goto_pixel(input int hx, input int vy);
    bit ok;
    int n;
    int off;
    wait_edge(1'b1, 1'b0, ok, n);
    if (!ok) begin
      check_cnt++;
      $display("FAIL goto_timeout: no VSYNC fall within %0d cycles", LIMIT);
    end else begin
      off = ((vy - (V_VIS + V_FP) + V_TOT) % V_TOT) * H_TOT + hx;
      repeat (2 * off) @(negedge clk);
    end
  endtask

  task automatic press(input bit nx, input bit pv);
    bus.BTN_NEXT = nx;
    bus.BTN_PREV = pv;
    repeat (PRESS_CYC / 2) @(negedge clk);
    bus.BTN_NEXT = 1'b0;
    bus.BTN_PREV = 1'b0;
    repeat (PRESS_CYC / 2) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.MODE = 1'b0;
    bus.BTN_NEXT = 1'b0;
    bus.BTN_PREV = 1'b0;
    repeat (4) @(negedge clk);
    check_cnt++; if (bus.VGA_R !== 4'h0) $display("FAIL reset_r: got %h want 0", bus.VGA_R); else pass_cnt++;
    check_cnt++; if (bus.VGA_G !== 4'h0) $display("FAIL reset_g: got %h want 0", bus.VGA_G); else pass_cnt++;
    check_cnt++; if (bus.VGA_B !== 4'h0) $display("FAIL reset_b: got %h want 0", bus.VGA_B); else pass_cnt++;
    check_cnt++; if (bus.VGA_HSYNC !== 1'b1) $display("FAIL reset_hs: got %b want 1", bus.VGA_HSYNC); else pass_cnt++;
    check_cnt++; if (bus.VGA_VSYNC !== 1'b1) $display("FAIL reset_vs: got %b want 1", bus.VGA_VSYNC); else pass_cnt++;
    rst_n = 1'b1;
  endtask

  task automatic test_sync_timing;
    bit ok0, ok1, ok2;
    int n0, n_low, n_high;
    for (int s = 0; s < 2; s++) begin
      wait_edge(s[0], 1'b0, ok0, n0);
      wait_edge(s[0], 1'b1, ok1, n_low);
      wait_edge(s[0], 1'b0, ok2, n_high);
      check_cnt++;
      if (!(ok0 && ok1 && ok2) || n_low !== (s == 0 ? 16 : 320))
        $display("FAIL sync%0d_low: got %0d clocks want %0d", s, n_low, (s == 0 ? 16 : 320));
      else pass_cnt++;
      check_cnt++;
      if (!(ok0 && ok1 && ok2) || (n_low + n_high) !== (s == 0 ? 160 : 2240))
        $display("FAIL sync%0d_period: got %0d clocks want %0d", s, n_low + n_high, (s == 0 ? 160 : 2240));
      else pass_cnt++;
    end
  endtask

  task automatic test_default_color;
    goto_pixel(5, 1);
    check_cnt++; if (rgb !== 12'h000) $display("FAIL default_rgb: got %h want 000", rgb); else pass_cnt++;
  endtask

  task automatic test_next_clean;
    goto_pixel(5, 1);
    press(1'b1, 1'b0);
    repeat (4 * H_TOT * 2 - PRESS_CYC) @(negedge clk);
    check_cnt++; if (rgb !== 12'h000) $display("FAIL next_midframe: got %h want 000", rgb); else pass_cnt++;
    goto_pixel(5, 1);
    check_cnt++; if (rgb !== 12'hF00) $display("FAIL next_newframe: got %h want F00", rgb); else pass_cnt++;
    repeat (2 * (H_VIS + 1 - 5)) @(negedge clk);
    check_cnt++; if (rgb !== 12'h000) $display("FAIL hblank: got %h want 000", rgb); else pass_cnt++;
  endtask

  task automatic test_bounce;
    for (int i = 0; i < 5; i++) begin
      bus.BTN_NEXT = 1'b1;
      repeat (3) @(negedge clk);
      bus.BTN_NEXT = 1'b0;
      repeat (3) @(negedge clk);
    end
    bus.BTN_NEXT = 1'b1;
    repeat (20) @(negedge clk);
    bus.BTN_NEXT = 1'b0;
    repeat (30) @(negedge clk);
    goto_pixel(5, 1);
    check_cnt++; if (rgb !== 12'h0F0) $display("FAIL bounce_one_step: got %h want 0F0", rgb); else pass_cnt++;
  endtask

  task automatic test_wrap_and_both;
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    goto_pixel(5, 1);
    check_cnt++; if (rgb !== 12'h000) $display("FAIL prev_to_0: got %h want 000", rgb); else pass_cnt++;
    press(1'b0, 1'b1);
    goto_pixel(5, 1);
    check_cnt++; if (rgb !== 12'hFFF) $display("FAIL prev_wrap_7: got %h want FFF", rgb); else pass_cnt++;
    press(1'b1, 1'b0);
    goto_pixel(5, 1);
    check_cnt++; if (rgb !== 12'h000) $display("FAIL next_wrap_0: got %h want 000", rgb); else pass_cnt++;
    press(1'b1, 1'b0);
    press(1'b1, 1'b1);
    goto_pixel(5, 1);
    check_cnt++; if (rgb !== 12'hF00) $display("FAIL both_unchanged: got %h want F00", rgb); else pass_cnt++;
    press(1'b1, 1'b0);
    goto_pixel(5, 1);
    check_cnt++; if (rgb !== 12'h0F0) $display("FAIL index_2: got %h want 0F0", rgb); else pass_cnt++;
  endtask

  task automatic test_bars;
    bus.MODE = 1'b1;
    repeat (2 * (2 * H_TOT + 55)) @(negedge clk);
    check_cnt++; if (rgb !== 12'h0F0) $display("FAIL mode_midframe: got %h want 0F0", rgb); else pass_cnt++;
    goto_pixel(3, 1);
    check_cnt++; if (rgb !== 12'h0F0) $display("FAIL bar0: got %h want 0F0", rgb); else pass_cnt++;
    repeat (2 * 24) @(negedge clk);
    check_cnt++; if (rgb !== 12'hF0F) $display("FAIL bar3: got %h want F0F", rgb); else pass_cnt++;
    repeat (2 * 33) @(negedge clk);
    check_cnt++; if (rgb !== 12'hF00) $display("FAIL bar7: got %h want F00", rgb); else pass_cnt++;
    repeat (2 * 5) @(negedge clk);
    check_cnt++; if (rgb !== 12'hF00) $display("FAIL bar_remainder: got %h want F00", rgb); else pass_cnt++;
    repeat (2 * 3) @(negedge clk);
    check_cnt++; if (rgb !== 12'h000) $display("FAIL bar_blank: got %h want 000", rgb); else pass_cnt++;
  endtask

  task automatic test_reset_held_button;
    goto_pixel(10, 5);
    check_cnt++; if (rgb !== 12'hFF0) $display("FAIL pre_reset_bar1: got %h want FF0", rgb); else pass_cnt++;
    bus.BTN_NEXT = 1'b1;
    rst_n = 1'b0;
    #1;
    check_cnt++; if (rgb !== 12'h000) $display("FAIL midreset_rgb: got %h want 000", rgb); else pass_cnt++;
    check_cnt++;
    if ({bus.VGA_HSYNC, bus.VGA_VSYNC} !== 2'b11)
      $display("FAIL midreset_sync: got %b want 11", {bus.VGA_HSYNC, bus.VGA_VSYNC});
    else pass_cnt++;
    bus.MODE = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (PRESS_CYC) @(negedge clk);
    goto_pixel(5, 1);
    check_cnt++; if (rgb !== 12'h000) $display("FAIL held_no_press: got %h want 000", rgb); else pass_cnt++;
    bus.BTN_NEXT = 1'b0;
    repeat (30) @(negedge clk);
    press(1'b1, 1'b0);
    goto_pixel(5, 1);
    check_cnt++; if (rgb !== 12'hF00) $display("FAIL repress_after_reset: got %h want F00", rgb); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_sync_timing();
    test_default_color();
    test_next_clean();
    test_bounce();
    test_wrap_and_both();
    test_bars();
    test_reset_held_button();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule
